axis_pkt_sink: RTL and testbench

//  AXI4-Stream packet receiver on the read (master) side of the 64-bit AXIS FIFO. Consumes beats with tkeep/tlast and

---
 rtl/axis_pkt_sink.sv | 215 +++++++++++++++++++++
 tb/tb_axis_pkt_sink.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_sink.sv
// AXI4-Stream packet sink: measures each packet (bytes, beats, masked XOR, framing errors) and emits one descriptor.
// Define AXIS_PKT_SINK_STATS_EN to add the stat_pkts/stat_errs counters.
module axis_pkt_sink #(
    parameter int DATA_W    = 64,
    parameter int KEEP_W    = DATA_W / 8,
    parameter int LEN_W     = 16,
    parameter int MAX_BYTES = 9600
) (
    input  logic              s_aclk,
    input  logic              s_aresetn,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic [KEEP_W-1:0] s_axis_tkeep,
    input  logic              s_axis_tlast,
    output logic              pkt_valid,
    input  logic              pkt_ready,
    output logic [LEN_W-1:0]  pkt_bytes,
    output logic [LEN_W-1:0]  pkt_beats,
    output logic [DATA_W-1:0] pkt_xor,
    output logic [2:0]        pkt_err
`ifdef AXIS_PKT_SINK_STATS_EN
    ,
    output logic [31:0]       stat_pkts,
    output logic [31:0]       stat_errs
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BODY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] MAX_BYTES_L = LEN_W'(MAX_BYTES);

    state_t             state_q, state_d;
    logic               readyEn_q;
    logic [LEN_W-1:0]   bytes_q, bytes_d;
    logic [LEN_W-1:0]   beats_q, beats_d;
    logic [DATA_W-1:0]  xor_q, xor_d;
    logic [2:0]         err_q, err_d;
    logic               pktValid_q, pktValid_d;
    logic [LEN_W-1:0]   pktBytes_q, pktBytes_d;
    logic [LEN_W-1:0]   pktBeats_q, pktBeats_d;
    logic [DATA_W-1:0]  pktXor_q, pktXor_d;
    logic [2:0]         pktErr_q, pktErr_d;

    logic               tready;
    logic               xorFreeze;
    logic               beatTaken;
    logic               lastTaken;
    logic [LEN_W:0]     keepCount;
    logic [LEN_W:0]     bytesSum;
    logic [LEN_W-1:0]   bytesNew;
    logic [LEN_W-1:0]   beatsNew;
    logic [DATA_W-1:0]  byteMask;
    logic [DATA_W-1:0]  xorNew;
    logic [2:0]         errNew;
    logic               keepFull;
    logic               lastKeepOk;

    assign beatTaken = s_axis_tvalid & tready;
    assign lastTaken = beatTaken & s_axis_tlast;

    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Oversize packets park in DRAIN until their tlast so the remainder is discarded.
    always_comb begin
        state_d = state_q;
        if (beatTaken) begin
            if (s_axis_tlast) begin
                state_d = IDLE;
            end else if (state_q == DRAIN || errNew[2]) begin
                state_d = DRAIN;
            end else begin
                state_d = BODY;
            end
        end
    end

    // A pending descriptor only blocks the stream while it is not being taken this cycle.
    always_comb begin
        xorFreeze = (state_q == DRAIN);
        tready    = readyEn_q & (~pktValid_q | pkt_ready);
    end

    always_comb begin
        keepCount = '0;
        byteMask  = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            keepCount            = keepCount + {{LEN_W{1'b0}}, s_axis_tkeep[i]};
            byteMask[8*i +: 8]   = {8{s_axis_tkeep[i]}};
        end
        bytesSum   = {1'b0, bytes_q} + keepCount;
        bytesNew   = bytesSum[LEN_W] ? '1 : bytesSum[LEN_W-1:0];
        beatsNew   = (&beats_q) ? beats_q : beats_q + LEN_W'(1);
        keepFull   = &s_axis_tkeep;
        lastKeepOk = (s_axis_tkeep != '0) &&
                     ((s_axis_tkeep & (s_axis_tkeep + KEEP_W'(1))) == '0);
        xorNew     = xorFreeze ? xor_q : (xor_q ^ (s_axis_tdata & byteMask));
        errNew[2]  = err_q[2] | (bytesNew > MAX_BYTES_L);
        errNew[1]  = err_q[1] | (s_axis_tlast & ~lastKeepOk);
        errNew[0]  = err_q[0] | (~s_axis_tlast & ~keepFull);
    end

    always_comb begin
        bytes_d = bytes_q;
        beats_d = beats_q;
        xor_d   = xor_q;
        err_d   = err_q;
        if (lastTaken) begin
            bytes_d = '0;
            beats_d = '0;
            xor_d   = '0;
            err_d   = '0;
        end else if (beatTaken) begin
            bytes_d = bytesNew;
            beats_d = beatsNew;
            xor_d   = xorNew;
            err_d   = errNew;
        end
    end

    // A tlast on the same edge as a descriptor handshake reloads without a bubble.
    always_comb begin
        pktValid_d = pktValid_q;
        pktBytes_d = pktBytes_q;
        pktBeats_d = pktBeats_q;
        pktXor_d   = pktXor_q;
        pktErr_d   = pktErr_q;
        if (lastTaken) begin
            pktValid_d = 1'b1;
            pktBytes_d = bytesNew;
            pktBeats_d = beatsNew;
            pktXor_d   = xorNew;
            pktErr_d   = errNew;
        end else if (pktValid_q && pkt_ready) begin
            pktValid_d = 1'b0;
            pktBytes_d = '0;
            pktBeats_d = '0;
            pktXor_d   = '0;
            pktErr_d   = '0;
        end
    end

    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            readyEn_q  <= 1'b0;
            bytes_q    <= '0;
            beats_q    <= '0;
            xor_q      <= '0;
            err_q      <= '0;
            pktValid_q <= 1'b0;
            pktBytes_q <= '0;
            pktBeats_q <= '0;
            pktXor_q   <= '0;
            pktErr_q   <= '0;
        end else begin
            readyEn_q  <= 1'b1;
            bytes_q    <= bytes_d;
            beats_q    <= beats_d;
            xor_q      <= xor_d;
            err_q      <= err_d;
            pktValid_q <= pktValid_d;
            pktBytes_q <= pktBytes_d;
            pktBeats_q <= pktBeats_d;
            pktXor_q   <= pktXor_d;
            pktErr_q   <= pktErr_d;
        end
    end

    assign s_axis_tready = tready;
    assign pkt_valid     = pktValid_q;
    assign pkt_bytes     = pktBytes_q;
    assign pkt_beats     = pktBeats_q;
    assign pkt_xor       = pktXor_q;
    assign pkt_err       = pktErr_q;

`ifdef AXIS_PKT_SINK_STATS_EN
    logic [31:0] statPkts_q, statPkts_d;
    logic [31:0] statErrs_q, statErrs_d;

    always_comb begin
        statPkts_d = statPkts_q;
        statErrs_d = statErrs_q;
        if (lastTaken) begin
            statPkts_d = statPkts_q + 32'd1;
            if (errNew != 3'b000) begin
                statErrs_d = statErrs_q + 32'd1;
            end
        end
    end

    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            statPkts_q <= '0;
            statErrs_q <= '0;
        end else begin
            statPkts_q <= statPkts_d;
            statErrs_q <= statErrs_d;
        end
    end

    assign stat_pkts = statPkts_q;
    assign stat_errs = statErrs_q;
`endif

endmodule

// File: tb/tb_axis_pkt_sink.sv
// Scoreboard bench for axis_pkt_sink: instance A uses the default byte limit, instance B a 16-byte limit.
// Stimulus pushes expected descriptors; per-instance monitors pop and compare on each descriptor handshake.
module tb_axis_pkt_sink;

    typedef struct {
        logic [15:0] bytes;
        logic [15:0] beats;
        logic [63:0] xr;
        logic [2:0]  err;
    } desc_t;

    logic        clk = 1'b0;
    logic        rstN;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast;

    logic        tvalidA, treadyA, pktValidA, pktReadyA;
    logic [15:0] pktBytesA, pktBeatsA;
    logic [63:0] pktXorA;
    logic [2:0]  pktErrA;
    logic        tvalidB, treadyB, pktValidB, pktReadyB;
    logic [15:0] pktBytesB, pktBeatsB;
    logic [63:0] pktXorB;
    logic [2:0]  pktErrB;
`ifdef AXIS_PKT_SINK_STATS_EN
    logic [31:0] statPktsA, statErrsA, statPktsB, statErrsB;
`endif

    desc_t expA[$];
    desc_t expB[$];
    desc_t eA, eB;
    int    checks = 0;
    int    errors = 0;
    int    cntPktsA = 0, cntErrsA = 0, cntPktsB = 0, cntErrsB = 0;

    always #5 clk = ~clk;

    axis_pkt_sink dutA (
        .s_aclk(clk), .s_aresetn(rstN),
        .s_axis_tvalid(tvalidA), .s_axis_tready(treadyA),
        .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tlast(tlast),
        .pkt_valid(pktValidA), .pkt_ready(pktReadyA),
        .pkt_bytes(pktBytesA), .pkt_beats(pktBeatsA), .pkt_xor(pktXorA), .pkt_err(pktErrA)
`ifdef AXIS_PKT_SINK_STATS_EN
        , .stat_pkts(statPktsA), .stat_errs(statErrsA)
`endif
    );

    axis_pkt_sink #(.MAX_BYTES(16)) dutB (
        .s_aclk(clk), .s_aresetn(rstN),
        .s_axis_tvalid(tvalidB), .s_axis_tready(treadyB),
        .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tlast(tlast),
        .pkt_valid(pktValidB), .pkt_ready(pktReadyB),
        .pkt_bytes(pktBytesB), .pkt_beats(pktBeatsB), .pkt_xor(pktXorB), .pkt_err(pktErrB)
`ifdef AXIS_PKT_SINK_STATS_EN
        , .stat_pkts(statPktsB), .stat_errs(statErrsB)
`endif
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic compareDesc(input string tag, input desc_t e, input logic [15:0] b,
                               input logic [15:0] bt, input logic [63:0] x, input logic [2:0] er);
        checkOutput({tag, ".bytes"}, {48'd0, b}, {48'd0, e.bytes});
        checkOutput({tag, ".beats"}, {48'd0, bt}, {48'd0, e.beats});
        checkOutput({tag, ".xor"}, x, e.xr);
        checkOutput({tag, ".err"}, {61'd0, er}, {61'd0, e.err});
    endtask

    // Monitors: a descriptor sampled valid&ready on the falling edge is consumed at the next rising edge.
    always @(negedge clk) begin
        if (rstN && pktValidA && pktReadyA) begin
            if (expA.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedDescA: actual bytes=%0d required no descriptor", pktBytesA);
            end else begin
                eA = expA.pop_front();
                compareDesc("descA", eA, pktBytesA, pktBeatsA, pktXorA, pktErrA);
            end
        end
    end

    always @(negedge clk) begin
        if (rstN && pktValidB && pktReadyB) begin
            if (expB.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedDescB: actual bytes=%0d required no descriptor", pktBytesB);
            end else begin
                eB = expB.pop_front();
                compareDesc("descB", eB, pktBytesB, pktBeatsB, pktXorB, pktErrB);
            end
        end
    end

    task automatic pushExp(input bit sel, input int by, input int be, input logic [63:0] x, input logic [2:0] er);
        desc_t d;
        d.bytes = 16'(by);
        d.beats = 16'(be);
        d.xr    = x;
        d.err   = er;
        if (sel) begin
            expB.push_back(d);
            cntPktsB++;
            if (er != 3'b000) cntErrsB++;
        end else begin
            expA.push_back(d);
            cntPktsA++;
            if (er != 3'b000) cntErrsA++;
        end
    endtask

    // Drives one beat to instance sel and returns #1 after the edge that accepts it.
    task automatic applyStimulus(input bit sel, input logic [63:0] d, input logic [7:0] k, input logic l);
        int  waitCycles = 0;
        bit  timedOut = 0;
        tdata = d;
        tkeep = k;
        tlast = l;
        if (sel) tvalidB = 1'b1; else tvalidA = 1'b1;
        forever begin
            @(negedge clk);
            if (sel ? treadyB : treadyA) break;
            waitCycles++;
            if (waitCycles > 200) begin
                timedOut = 1;
                break;
            end
        end
        if (timedOut) begin
            checks++;
            errors++;
            $display("[TB] FAIL beatTimeout: actual tready=0 for 200 cycles required 1");
        end else begin
            @(posedge clk);
        end
        #1;
        tvalidA = 1'b0;
        tvalidB = 1'b0;
        tlast   = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: actual simulation still running required finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstN = 1'b1;
        tvalidA = 1'b0; tvalidB = 1'b0;
        tdata = '0; tkeep = '0; tlast = 1'b0;
        pktReadyA = 1'b1; pktReadyB = 1'b1;
        #2 rstN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst.treadyA", {63'd0, treadyA}, 64'd0);
        checkOutput("rst.pktValidA", {63'd0, pktValidA}, 64'd0);
        checkOutput("rst.bytesA", {48'd0, pktBytesA}, 64'd0);
        checkOutput("rst.xorA", pktXorA, 64'd0);
        checkOutput("rst.treadyB", {63'd0, treadyB}, 64'd0);
        rstN = 1'b1;
        #1 checkOutput("rel.treadyBeforeEdge", {63'd0, treadyA}, 64'd0);
        @(posedge clk);
        #1 checkOutput("rel.treadyAfterEdge", {63'd0, treadyA}, 64'd1);

        // Single beat, last keep not contiguous from byte 0.
        pushExp(0, 6, 1, 64'hFFFF0000FFFFFFFF, 3'b010);
        checkOutput("t2.validBefore", {63'd0, pktValidA}, 64'd0);
        applyStimulus(0, 64'hFFFFFFFFFFFFFFFF, 8'hCF, 1'b1);
        checkOutput("t2.validAfter", {63'd0, pktValidA}, 64'd1);
        @(posedge clk); #1;

        // Four full beats; the descriptor is then held back by pkt_ready=0.
        pushExp(0, 32, 4, 64'h4444444444444444, 3'b000);
        applyStimulus(0, 64'h1111111111111111, 8'hFF, 1'b0);
        applyStimulus(0, 64'h2222222222222222, 8'hFF, 1'b0);
        applyStimulus(0, 64'h3333333333333333, 8'hFF, 1'b0);
        pktReadyA = 1'b0;
        applyStimulus(0, 64'h4444444444444444, 8'hFF, 1'b1);

        pushExp(0, 8, 1, 64'h5555555555555555, 3'b000);
        tdata = 64'h5555555555555555; tkeep = 8'hFF; tlast = 1'b1; tvalidA = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("t4.treadyHeld", {63'd0, treadyA}, 64'd0);
            checkOutput("t4.bytesStable", {48'd0, pktBytesA}, 64'd32);
        end
        @(posedge clk); #1;
        pktReadyA = 1'b1;
        #1 checkOutput("t4.treadyComb", {63'd0, treadyA}, 64'd1);
        @(posedge clk); #1;
        tvalidA = 1'b0; tlast = 1'b0;
        checkOutput("t4.backToBack", {63'd0, pktValidA}, 64'd1);
        @(posedge clk); #1;

        // Byte-limit boundary cases on the 16-byte instance.
        pushExp(1, 16, 2, 64'h0303030303030303, 3'b000);
        applyStimulus(1, 64'h0101010101010101, 8'hFF, 1'b0);
        applyStimulus(1, 64'h0202020202020202, 8'hFF, 1'b1);
        pushExp(1, 24, 3, 64'h0707070707070707, 3'b100);
        applyStimulus(1, 64'h0101010101010101, 8'hFF, 1'b0);
        applyStimulus(1, 64'h0202020202020202, 8'hFF, 1'b0);
        applyStimulus(1, 64'h0404040404040404, 8'hFF, 1'b1);
        pushExp(1, 32, 4, 64'h0707070707070707, 3'b100);
        applyStimulus(1, 64'h0101010101010101, 8'hFF, 1'b0);
        applyStimulus(1, 64'h0202020202020202, 8'hFF, 1'b0);
        applyStimulus(1, 64'h0404040404040404, 8'hFF, 1'b0);
        applyStimulus(1, 64'h0808080808080808, 8'hFF, 1'b1);
        pushExp(1, 12, 2, 64'h12345678B89EFCD2, 3'b001);
        applyStimulus(1, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 1'b0);
        applyStimulus(1, 64'h1234567812345678, 8'hFF, 1'b1);
        pushExp(1, 0, 1, 64'h0, 3'b010);
        applyStimulus(1, 64'hDEADBEEFDEADBEEF, 8'h00, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // Reset in the middle of a packet discards it.
        applyStimulus(0, 64'h9999999999999999, 8'hFF, 1'b0);
        applyStimulus(0, 64'h8888888888888888, 8'hFF, 1'b0);
`ifdef AXIS_PKT_SINK_STATS_EN
        checkOutput("stat.pktsB", {32'd0, statPktsB}, 64'(cntPktsB));
        checkOutput("stat.errsB", {32'd0, statErrsB}, 64'(cntErrsB));
`endif
        rstN = 1'b0;
        cntPktsA = 0;
        cntErrsA = 0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("t6.treadyInReset", {63'd0, treadyA}, 64'd0);
        checkOutput("t6.validInReset", {63'd0, pktValidA}, 64'd0);
        rstN = 1'b1;
        @(posedge clk); #1;
        pushExp(0, 1, 1, 64'h00000000000000AB, 3'b000);
        applyStimulus(0, 64'h00000000000000AB, 8'h01, 1'b1);

        for (int i = 0; i < 50; i++) begin
            if (expA.size() == 0 && expB.size() == 0) break;
            @(posedge clk);
        end
        #1;
        checkOutput("end.queueA", 64'(expA.size()), 64'd0);
        checkOutput("end.queueB", 64'(expB.size()), 64'd0);
`ifdef AXIS_PKT_SINK_STATS_EN
        checkOutput("stat.pktsA", {32'd0, statPktsA}, 64'(cntPktsA));
        checkOutput("stat.errsA", {32'd0, statErrsA}, 64'(cntErrsA));
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
